fsfifo_ext: RTL and testbench

- Parametrised single-clock synchronous FIFO that succeeds the basic full-synchronous FIFO. Adds:
  - a selectable first-word-fall-through (FWFT) read mode;
  - a fill-level output and programmable almost-full/almost-empty flags;
  - a synchronous flush;
  - sticky overflow/underflow error flags.
- Sits between the detector-side data producers and the SQT56 bridge readout path as the general-purpose buffering element.

---
 rtl/fsfifo_ext_pkg.sv | 19 +
 rtl/fsfifo_mem.sv | 42 ++++
 rtl/fsfifo_ext.sv | 114 +++++++++++
 tb/tb_fsfifo_ext.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsfifo_ext_pkg.sv
// Shared helpers for the extended synchronous FIFO: level width and
// elaboration-time parameter legality.
package fsfifo_ext_pkg;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int width, input int depth, input int fwft,
                                        input int afull, input int aempty);
        return (width >= 1) && is_pow2(depth) && (fwft == 0 || fwft == 1) &&
               (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
    endfunction

endpackage

// File: rtl/fsfifo_mem.sv
// Simple dual-port storage for fsfifo_ext: synchronous write, registered
// (FWFT=0) or combinational (FWFT=1) read.
module fsfifo_mem #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int FWFT   = 0,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array is deliberately not reset so it can map onto RAM primitives.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_comb_read
        logic unused_rd;
        assign unused_rd = ^{rd_en, reset_ni};
        assign rd_data   = mem[rd_addr];
    end else begin : g_reg_read
        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                rd_data <= '0;
            end else if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/fsfifo_ext.sv
// Single-clock FIFO with optional first-word-fall-through, fill level,
// almost-full/empty thresholds, synchronous flush and sticky error flags.
module fsfifo_ext
    import fsfifo_ext_pkg::*;
#(
    parameter  int WIDTH         = 32,
    parameter  int DEPTH         = 16,
    parameter  int FWFT          = 0,
    parameter  int AFULL_THRESH  = DEPTH - 2,
    parameter  int AEMPTY_THRESH = 2,
    localparam int ADDR_W        = $clog2(DEPTH),
    localparam int LEVEL_W       = level_width(DEPTH)
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               flush_i,
    input  logic               clr_err_i,
    input  logic               wr_i,
    input  logic [WIDTH-1:0]   wr_data_i,
    input  logic               rd_i,
    output logic [WIDTH-1:0]   rd_data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               almost_full_o,
    output logic               almost_empty_o,
    output logic [LEVEL_W-1:0] level_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    if (!params_legal(WIDTH, DEPTH, FWFT, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
        $error("fsfifo_ext: illegal parameter combination");
    end

    localparam logic [LEVEL_W-1:0] DEPTH_L  = LEVEL_W'(DEPTH);
    localparam logic [LEVEL_W-1:0] AFULL_L  = LEVEL_W'(AFULL_THRESH);
    localparam logic [LEVEL_W-1:0] AEMPTY_L = LEVEL_W'(AEMPTY_THRESH);
    localparam logic [LEVEL_W-1:0] PTR_ONE  = LEVEL_W'(1);

    logic [LEVEL_W-1:0] wr_ptr, rd_ptr, level;
    logic               full, empty;
    logic               wr_acc, rd_acc, wr_rej, rd_rej;
    logic [WIDTH-1:0]   mem_rd_data;

    // Pointers carry one extra bit, so their plain difference is the level, wrap included.
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);

    always_comb begin
        rd_acc = rd_i && !empty && !flush_i;
        wr_acc = wr_i && (!full || rd_acc) && !flush_i;
        wr_rej = wr_i && !flush_i && !wr_acc;
        rd_rej = rd_i && !flush_i && !rd_acc;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // A new rejection in the same cycle as clr_err_i keeps the flag set.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (flush_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_rej)         overflow_o  <= 1'b1;
            else if (clr_err_i) overflow_o  <= 1'b0;
            if (rd_rej)         underflow_o <= 1'b1;
            else if (clr_err_i) underflow_o <= 1'b0;
        end
    end

    fsfifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .FWFT   (FWFT),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .wr_en    (wr_acc),
        .wr_addr  (wr_ptr[ADDR_W-1:0]),
        .wr_data  (wr_data_i),
        .rd_en    (rd_acc),
        .rd_addr  (rd_ptr[ADDR_W-1:0]),
        .rd_data  (mem_rd_data)
    );

    if (FWFT != 0) begin : g_fwft_out
        assign rd_data_o = empty ? '0 : mem_rd_data;
    end else begin : g_std_out
        assign rd_data_o = mem_rd_data;
    end

    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (level >= AFULL_L);
    assign almost_empty_o = (level <= AEMPTY_L);
    assign level_o        = level;

endmodule

// File: tb/tb_fsfifo_ext.sv
// Self-checking bench: a standard-read and an FWFT instance share stimulus and
// are compared each cycle against a queue-based reference model.
module tb_fsfifo_ext;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [4:0]       level;
        logic             full;
        logic             empty;
        logic             af;
        logic             ae;
        logic             ovf;
        logic             unf;
        logic [WIDTH-1:0] rd_data;
    } obs_t;

    logic             clk_i = 1'b0;
    logic             reset_ni = 1'b0;
    logic             flush_i = 1'b0;
    logic             clr_err_i = 1'b0;
    logic             wr_i = 1'b0;
    logic [WIDTH-1:0] wr_data_i = '0;
    logic             rd_i = 1'b0;

    logic [WIDTH-1:0] rd_data [2];
    logic             full [2];
    logic             empty [2];
    logic             af [2];
    logic             ae [2];
    logic [4:0]       lvl [2];
    logic             ovf [2];
    logic             unf [2];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] m_rd_reg;
    bit               m_ovf, m_unf;

    always #5 clk_i = ~clk_i;

    fsfifo_ext #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_dut0 (
        .clk_i(clk_i), .reset_ni(reset_ni), .flush_i(flush_i), .clr_err_i(clr_err_i),
        .wr_i(wr_i), .wr_data_i(wr_data_i), .rd_i(rd_i), .rd_data_o(rd_data[0]),
        .full_o(full[0]), .empty_o(empty[0]), .almost_full_o(af[0]), .almost_empty_o(ae[0]),
        .level_o(lvl[0]), .overflow_o(ovf[0]), .underflow_o(unf[0])
    );

    fsfifo_ext #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_dut1 (
        .clk_i(clk_i), .reset_ni(reset_ni), .flush_i(flush_i), .clr_err_i(clr_err_i),
        .wr_i(wr_i), .wr_data_i(wr_data_i), .rd_i(rd_i), .rd_data_o(rd_data[1]),
        .full_o(full[1]), .empty_o(empty[1]), .almost_full_o(af[1]), .almost_empty_o(ae[1]),
        .level_o(lvl[1]), .overflow_o(ovf[1]), .underflow_o(unf[1])
    );

    function automatic void model_reset();
        q.delete();
        m_rd_reg = '0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endfunction

    function automatic void model_step(input bit wr, input logic [WIDTH-1:0] d, input bit rd,
                                       input bit fl, input bit clr);
        bit rd_ok, wr_ok;
        if (fl) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        rd_ok = rd && (q.size() > 0);
        wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
        m_ovf = (wr && !wr_ok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = (rd && !rd_ok) ? 1'b1 : (clr ? 1'b0 : m_unf);
        if (rd_ok) m_rd_reg = q.pop_front();
        if (wr_ok) q.push_back(d);
    endfunction

    function automatic obs_t exp_obs(input int i);
        obs_t o;
        o.level   = 5'(q.size());
        o.full    = (q.size() == DEPTH);
        o.empty   = (q.size() == 0);
        o.af      = (q.size() >= DEPTH - 2);
        o.ae      = (q.size() <= 2);
        o.ovf     = m_ovf;
        o.unf     = m_unf;
        o.rd_data = (i == 0) ? m_rd_reg : ((q.size() > 0) ? q[0] : '0);
        return o;
    endfunction

    function automatic obs_t act_obs(input int i);
        obs_t o;
        o.level   = lvl[i];
        o.full    = full[i];
        o.empty   = empty[i];
        o.af      = af[i];
        o.ae      = ae[i];
        o.ovf     = ovf[i];
        o.unf     = unf[i];
        o.rd_data = rd_data[i];
        return o;
    endfunction

    // One clock: drive inputs, advance the model on the edge, sample 1 time unit later.
    task automatic cyc(input bit wr, input logic [WIDTH-1:0] d, input bit rd,
                       input bit fl = 1'b0, input bit clr = 1'b0);
        wr_i = wr; wr_data_i = d; rd_i = rd; flush_i = fl; clr_err_i = clr;
        @(posedge clk_i);
        model_step(wr, d, rd, fl, clr);
        #1;
        wr_i = 1'b0; rd_i = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        model_reset();
        #3;
        if ({act_obs(0), act_obs(1)} !== {exp_obs(0), exp_obs(1)}) begin
            miscompares++;
            $display("FAIL reset: got %h/%h want %h/%h", act_obs(0), act_obs(1), exp_obs(0), exp_obs(1));
        end
        vectors++;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
        cyc(0, '0, 0);
        if (lvl[0] !== 5'd0 || empty[1] !== 1'b1 || ae[0] !== 1'b1 || af[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: level=%0d empty=%b ae=%b af=%b want 0/1/1/0", lvl[0], empty[1], ae[0], af[1]);
        end
        vectors++;
    endtask

    task automatic test_fill();
        for (int k = 1; k <= DEPTH + 1; k++) begin
            cyc(1, WIDTH'(k), 0);
            if ({act_obs(0), act_obs(1)} !== {exp_obs(0), exp_obs(1)}) begin
                miscompares++;
                $display("FAIL fill[%0d]: got %h/%h want %h/%h", k, act_obs(0), act_obs(1), exp_obs(0), exp_obs(1));
            end
            vectors++;
        end
        if (full[0] !== 1'b1 || ovf[0] !== 1'b1 || ovf[1] !== 1'b1 || lvl[1] !== 5'd16) begin
            miscompares++;
            $display("FAIL fill_overflow: full=%b ovf=%b/%b level=%0d want 1/1/1/16", full[0], ovf[0], ovf[1], lvl[1]);
        end
        vectors++;
        cyc(0, '0, 0, 0, 1);
        if (ovf[0] !== 1'b0 || ovf[1] !== 1'b0 || lvl[0] !== 5'd16) begin
            miscompares++;
            $display("FAIL clr_err: ovf=%b/%b level=%0d want 0/0/16", ovf[0], ovf[1], lvl[0]);
        end
        vectors++;
    endtask

    task automatic test_full_rw();
        cyc(1, 32'h77, 1);
        if (lvl[0] !== 5'd16 || ovf[0] !== 1'b0 || unf[0] !== 1'b0 || rd_data[0] !== 32'h1) begin
            miscompares++;
            $display("FAIL full_rw: level=%0d ovf=%b unf=%b rd=%h want 16/0/0/1", lvl[0], ovf[0], unf[0], rd_data[0]);
        end
        vectors++;
        for (int k = 0; k < DEPTH; k++) begin
            cyc(0, '0, 1);
            if ({act_obs(0), act_obs(1)} !== {exp_obs(0), exp_obs(1)}) begin
                miscompares++;
                $display("FAIL drain[%0d]: got %h/%h want %h/%h", k, act_obs(0), act_obs(1), exp_obs(0), exp_obs(1));
            end
            vectors++;
        end
        if (rd_data[0] !== 32'h77 || empty[0] !== 1'b1 || rd_data[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL drain_last: rd0=%h empty=%b rd1=%h want 77/1/0", rd_data[0], empty[0], rd_data[1]);
        end
        vectors++;
    endtask

    task automatic test_set_wins();
        cyc(0, '0, 1);
        cyc(0, '0, 1, 0, 1);
        if (unf[0] !== 1'b1 || unf[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL set_wins: unf=%b/%b want 1/1", unf[0], unf[1]);
        end
        vectors++;
        cyc(0, '0, 0, 0, 1);
        if ({act_obs(0), act_obs(1)} !== {exp_obs(0), exp_obs(1)}) begin
            miscompares++;
            $display("FAIL set_wins_clr: got %h/%h want %h/%h", act_obs(0), act_obs(1), exp_obs(0), exp_obs(1));
        end
        vectors++;
    endtask

    task automatic test_std_read();
        cyc(1, 32'hA5, 0);
        cyc(0, '0, 1);
        if (rd_data[0] !== 32'hA5 || empty[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL std_read: rd=%h empty=%b want a5/1", rd_data[0], empty[0]);
        end
        vectors++;
        cyc(0, '0, 1);
        if (unf[0] !== 1'b1 || rd_data[0] !== 32'hA5 || rd_data[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL std_underflow: unf=%b rd0=%h rd1=%h want 1/a5/0", unf[0], rd_data[0], rd_data[1]);
        end
        vectors++;
        cyc(0, '0, 0, 0, 1);
    endtask

    task automatic test_fwft();
        cyc(1, 32'h11, 0);
        if (rd_data[1] !== 32'h11 || empty[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL fwft_head: rd=%h empty=%b want 11/0", rd_data[1], empty[1]);
        end
        vectors++;
        cyc(1, 32'h22, 0);
        cyc(0, '0, 1);
        if (rd_data[1] !== 32'h22 || rd_data[0] !== 32'h11) begin
            miscompares++;
            $display("FAIL fwft_pop: rd1=%h rd0=%h want 22/11", rd_data[1], rd_data[0]);
        end
        vectors++;
        cyc(0, '0, 1);
        if ({act_obs(0), act_obs(1)} !== {exp_obs(0), exp_obs(1)}) begin
            miscompares++;
            $display("FAIL fwft_drain: got %h/%h want %h/%h", act_obs(0), act_obs(1), exp_obs(0), exp_obs(1));
        end
        vectors++;
    endtask

    task automatic test_wrap();
        int n_wr = 0;
        int n_rd = 0;
        for (int k = 0; k < 600 && n_rd < 40; k++) begin
            bit w, r;
            w = (n_wr < 40) && (q.size() < 5) && (q.size() == 0 || $urandom_range(0, 1) == 1);
            r = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            n_wr += int'(w);
            n_rd += int'(r);
            cyc(w, $urandom(), r);
            if ({act_obs(0), act_obs(1)} !== {exp_obs(0), exp_obs(1)}) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got %h/%h want %h/%h", k, act_obs(0), act_obs(1), exp_obs(0), exp_obs(1));
            end
            vectors++;
        end
        if (n_rd != 40 || ovf[0] !== 1'b0 || unf[1] !== 1'b0 || lvl[0] !== 5'd0) begin
            miscompares++;
            $display("FAIL wrap_end: reads=%0d ovf=%b unf=%b level=%0d want 40/0/0/0", n_rd, ovf[0], unf[1], lvl[0]);
        end
        vectors++;
    endtask

    task automatic test_flush();
        for (int k = 0; k < 7; k++) cyc(1, $urandom(), 0);
        cyc(0, '0, 1);
        cyc(1, 32'hDEAD, 0, 1);
        if ({act_obs(0), act_obs(1)} !== {exp_obs(0), exp_obs(1)} || lvl[0] !== 5'd0) begin
            miscompares++;
            $display("FAIL flush: got %h/%h want %h/%h", act_obs(0), act_obs(1), exp_obs(0), exp_obs(1));
        end
        vectors++;
        cyc(0, '0, 1, 1);
        if (unf[0] !== 1'b0 || unf[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_rd: unf=%b/%b want 0/0", unf[0], unf[1]);
        end
        vectors++;
        cyc(1, 32'hBEEF, 0);
        cyc(0, '0, 1);
        if (rd_data[0] !== 32'hBEEF || empty[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_discard: rd=%h empty=%b want beef/1", rd_data[0], empty[0]);
        end
        vectors++;
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 9; k++) cyc(1, $urandom(), k == 8);
        cyc(1, $urandom(), 0);
        if (lvl[0] !== 5'd9) begin
            miscompares++;
            $display("FAIL areset_pre: level=%0d want 9", lvl[0]);
        end
        vectors++;
        #2;
        reset_ni = 1'b0;
        model_reset();
        #1;
        if ({act_obs(0), act_obs(1)} !== {exp_obs(0), exp_obs(1)} || rd_data[0] !== '0) begin
            miscompares++;
            $display("FAIL areset: got %h/%h want %h/%h", act_obs(0), act_obs(1), exp_obs(0), exp_obs(1));
        end
        vectors++;
        @(negedge clk_i);
        reset_ni = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) == 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
            if ({act_obs(0), act_obs(1)} !== {exp_obs(0), exp_obs(1)}) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h/%h want %h/%h", k, act_obs(0), act_obs(1), exp_obs(0), exp_obs(1));
            end
            vectors++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_rw();
        test_set_wins();
        test_std_read();
        test_fwft();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
